// File: rtl/inst_buffer_param.sv
// Parametrised instruction buffer between decode and rename/dispatch.
// Ports: clk/reset, flush_i, stall_i, decode write lanes in, dispatch group out.
module inst_buffer_param #(
  parameter int FETCH_WIDTH      = 8,
  parameter int DISPATCH_WIDTH   = 4,
  parameter int DEPTH            = 32,
  parameter int DEPTH_LOG        = 5,
  parameter int PKT_WIDTH        = 128,
  parameter int BR_BIT           = 100,
  parameter int PARTIAL_DISPATCH = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush_i,
  input  logic                                stall_i,
  input  logic                                decodeReady_i,
  input  logic [FETCH_WIDTH-1:0]              decodedVector_i,
  input  logic [FETCH_WIDTH*PKT_WIDTH-1:0]    decodedPacket_i,
  output logic                                stallFetch_o,
  output logic                                instBufferReady_o,
  output logic [DISPATCH_WIDTH-1:0]           dispatchVector_o,
  output logic [DISPATCH_WIDTH*PKT_WIDTH-1:0] decodedPacket_o,
  output logic [$clog2(DISPATCH_WIDTH):0]     branchCount_o,
  output logic [DEPTH_LOG:0]                  instCount_o
);

  localparam int FW_LOG = $clog2(FETCH_WIDTH) + 1;
  localparam int DW_LOG = $clog2(DISPATCH_WIDTH) + 1;

  typedef logic [DEPTH_LOG-1:0] ptr_t;
  typedef logic [DEPTH_LOG:0]   cnt_t;

  logic [PKT_WIDTH-1:0] mem_q [DEPTH];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t cnt_q, cnt_d;

  // off[k]: slot of lane k relative to tail (valid lanes below k)
  logic [FW_LOG-1:0]    off [FETCH_WIDTH];
  logic [FW_LOG-1:0]    wr_num;
  logic [DW_LOG-1:0]    avail;
  logic [PKT_WIDTH-1:0] lane;
  logic                 wr_en;
  logic                 deq;

  assign stallFetch_o = cnt_q > cnt_t'(DEPTH - FETCH_WIDTH);
  assign instCount_o  = cnt_q;
  assign wr_en = decodeReady_i & ~stallFetch_o & ~flush_i;
  assign instBufferReady_o = (avail != '0);
  assign deq = instBufferReady_o & ~stall_i & ~flush_i;

  always_comb begin
    off[0] = '0;
    for (int k = 1; k < FETCH_WIDTH; k++) begin
      off[k] = off[k-1] + FW_LOG'(decodedVector_i[k-1]);
    end
    wr_num = off[FETCH_WIDTH-1]
           + FW_LOG'(decodedVector_i[FETCH_WIDTH-1]);
  end

  always_comb begin
    avail = '0;
    if (cnt_q >= cnt_t'(DISPATCH_WIDTH)) begin
      avail = DW_LOG'(DISPATCH_WIDTH);
    end else if (PARTIAL_DISPATCH != 0) begin
      avail = DW_LOG'(cnt_q);
    end
  end

  always_comb begin
    lane          = '0;
    branchCount_o = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      lane = mem_q[head_q + ptr_t'(i)];
      dispatchVector_o[i] = (DW_LOG'(i) < avail);
      decodedPacket_o[i*PKT_WIDTH +: PKT_WIDTH] = lane;
      if (dispatchVector_o[i] && lane[BR_BIT]) begin
        branchCount_o = branchCount_o + DW_LOG'(1);
      end
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr_en) tail_d = tail_q + ptr_t'(wr_num);
      if (deq)   head_d = head_q + ptr_t'(avail);
      cnt_d = cnt_q
            + (wr_en ? cnt_t'(wr_num) : cnt_t'(0))
            - (deq ? cnt_t'(avail) : cnt_t'(0));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (decodedVector_i[k]) begin
          mem_q[tail_q + ptr_t'(off[k])] <=
            decodedPacket_i[k*PKT_WIDTH +: PKT_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_buffer_param.sv
// Testbench for inst_buffer_param: all-or-nothing and partial instances.
// Expected tags are queued on write and popped on dispatch.
module tb_inst_buffer_param;

  localparam int FW  = 8;
  localparam int DW  = 4;
  localparam int DEP = 32;
  localparam int PW  = 128;
  localparam int BR  = 100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic stall = 1'b0;
  logic dready = 1'b0;
  logic [FW-1:0] vec = '0;
  logic [FW*PW-1:0] din = '0;

  logic sf0, rdy0, sf1, rdy1;
  logic [DW-1:0] dv0, dv1;
  logic [DW*PW-1:0] dout0, dout1;
  logic [2:0] bc0, bc1;
  logic [5:0] cnt0, cnt1;

  int errs = 0;
  int checks = 0;
  int sb[$];
  int next_tag = 0;

  always #5 clk = ~clk;

  inst_buffer_param #(.PARTIAL_DISPATCH(0)) dut0 (
    .clk(clk), .reset(reset), .flush_i(flush),
    .stall_i(stall), .decodeReady_i(dready),
    .decodedVector_i(vec), .decodedPacket_i(din),
    .stallFetch_o(sf0), .instBufferReady_o(rdy0),
    .dispatchVector_o(dv0), .decodedPacket_o(dout0),
    .branchCount_o(bc0), .instCount_o(cnt0));

  inst_buffer_param #(.PARTIAL_DISPATCH(1)) dut1 (
    .clk(clk), .reset(reset), .flush_i(flush),
    .stall_i(stall), .decodeReady_i(dready),
    .decodedVector_i(vec), .decodedPacket_i(din),
    .stallFetch_o(sf1), .instBufferReady_o(rdy1),
    .dispatchVector_o(dv1), .decodedPacket_o(dout1),
    .branchCount_o(bc1), .instCount_o(cnt1));

  function automatic logic [PW-1:0] mkpkt(int tag, bit br);
    logic [PW-1:0] p;
    p = '0;
    p[31:0] = tag;
    p[BR] = br;
    return p;
  endfunction

  function automatic bit isbr(int t);
    return (t % 3) == 0;
  endfunction

  function automatic int tag0(int i);
    logic [PW-1:0] p;
    p = dout0[i*PW +: PW];
    return int'(p[31:0]);
  endfunction

  function automatic int tag1(int i);
    logic [PW-1:0] p;
    p = dout1[i*PW +: PW];
    return int'(p[31:0]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (sf0 !== 1'b0) begin errs++; $display("FAIL rst_sf got %b want 0", sf0); end
    checks++; if (rdy0 !== 1'b0) begin errs++; $display("FAIL rst_rdy got %b want 0", rdy0); end
    checks++; if (dv0 !== 4'h0) begin errs++; $display("FAIL rst_dv got %h want 0", dv0); end
    checks++; if (bc0 !== 3'd0) begin errs++; $display("FAIL rst_bc got %0d want 0", bc0); end
    checks++; if (cnt0 !== 6'd0) begin errs++; $display("FAIL rst_cnt got %0d want 0", cnt0); end
    #4 reset = 1'b1;
    step();
  endtask

  task automatic test_full_write();
    int ebc;
    stall = 1; dready = 1; vec = 8'hFF;
    for (int k = 0; k < FW; k++) begin
      din[k*PW +: PW] = mkpkt(k, isbr(k));
      sb.push_back(k);
    end
    step();
    dready = 0; vec = '0;
    checks++; if (cnt0 !== 6'd8) begin errs++; $display("FAIL full_cnt got %0d want 8", cnt0); end
    checks++; if (rdy0 !== 1'b1) begin errs++; $display("FAIL full_rdy got %b want 1", rdy0); end
    checks++; if (dv0 !== 4'hF) begin errs++; $display("FAIL full_dv got %h want f", dv0); end
    ebc = 0;
    for (int i = 0; i < DW; i++) begin
      ebc += int'(isbr(sb[i]));
      checks++;
      if (tag0(i) !== sb[i]) begin errs++; $display("FAIL full_lane%0d got %0d want %0d", i, tag0(i), sb[i]); end
    end
    checks++; if (int'(bc0) !== ebc) begin errs++; $display("FAIL full_bc got %0d want %0d", bc0, ebc); end
    stall = 0;
    step();
    repeat (4) void'(sb.pop_front());
    checks++; if (cnt0 !== 6'd4) begin errs++; $display("FAIL full_cnt2 got %0d want 4", cnt0); end
    for (int i = 0; i < DW; i++) begin
      checks++;
      if (tag0(i) !== sb[i]) begin errs++; $display("FAIL full2_lane%0d got %0d want %0d", i, tag0(i), sb[i]); end
    end
    step();
    repeat (4) void'(sb.pop_front());
    checks++; if (cnt0 !== 6'd0) begin errs++; $display("FAIL full_cnt3 got %0d want 0", cnt0); end
    checks++; if (rdy0 !== 1'b0) begin errs++; $display("FAIL full_rdy3 got %b want 0", rdy0); end
    stall = 1;
  endtask

  task automatic test_sparse();
    int ebc;
    stall = 1; dready = 1; vec = 8'b1010_0101;
    for (int k = 0; k < FW; k++) begin
      din[k*PW +: PW] = mkpkt(k, isbr(k));
      if (vec[k]) sb.push_back(k);
    end
    step();
    dready = 0; vec = '0;
    checks++; if (cnt0 !== 6'd4) begin errs++; $display("FAIL sparse_cnt got %0d want 4", cnt0); end
    ebc = 0;
    for (int i = 0; i < DW; i++) begin
      ebc += int'(isbr(sb[i]));
      checks++;
      if (tag0(i) !== sb[i]) begin errs++; $display("FAIL sparse_lane%0d got %0d want %0d", i, tag0(i), sb[i]); end
    end
    checks++; if (int'(bc0) !== ebc) begin errs++; $display("FAIL sparse_bc got %0d want %0d", bc0, ebc); end
    flush = 1;
    step();
    flush = 0;
    sb.delete();
    checks++; if (cnt0 !== 6'd0) begin errs++; $display("FAIL sparse_flush got %0d want 0", cnt0); end
  endtask

  task automatic test_partial();
    // leave branch packets in slots 0..3, then flush
    stall = 1; dready = 1; vec = 8'h0F;
    for (int k = 0; k < FW; k++) din[k*PW +: PW] = mkpkt(1000 + k, 1'b1);
    step();
    dready = 0; flush = 1;
    step();
    flush = 0;
    vec = 8'b0000_0111; dready = 1; stall = 0;
    for (int k = 0; k < FW; k++) din[k*PW +: PW] = mkpkt(200 + k, k == 1);
    step();
    dready = 0; vec = '0;
    checks++; if (cnt1 !== 6'd3) begin errs++; $display("FAIL part_cnt got %0d want 3", cnt1); end
    checks++; if (dv1 !== 4'b0111) begin errs++; $display("FAIL part_dv got %b want 0111", dv1); end
    checks++; if (rdy1 !== 1'b1) begin errs++; $display("FAIL part_rdy got %b want 1", rdy1); end
    checks++; if (bc1 !== 3'd1) begin errs++; $display("FAIL part_bc got %0d want 1", bc1); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tag1(i) !== 200 + i) begin errs++; $display("FAIL part_lane%0d got %0d want %0d", i, tag1(i), 200 + i); end
    end
    checks++; if (rdy0 !== 1'b0) begin errs++; $display("FAIL grp_rdy got %b want 0", rdy0); end
    checks++; if (dv0 !== 4'h0) begin errs++; $display("FAIL grp_dv got %h want 0", dv0); end
    step();
    checks++; if (cnt1 !== 6'd0) begin errs++; $display("FAIL part_cnt2 got %0d want 0", cnt1); end
    checks++; if (rdy1 !== 1'b0) begin errs++; $display("FAIL part_rdy2 got %b want 0", rdy1); end
    checks++; if (cnt0 !== 6'd3) begin errs++; $display("FAIL grp_cnt got %0d want 3", cnt0); end
    flush = 1;
    step();
    flush = 0; stall = 1;
  endtask

  task automatic test_fill();
    int mc;
    bit acc;
    mc = 0;
    stall = 1; dready = 1; vec = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      acc = (mc <= DEP - FW);
      for (int k = 0; k < FW; k++) din[k*PW +: PW] = mkpkt(next_tag + k, isbr(next_tag + k));
      if (acc) begin
        for (int k = 0; k < FW; k++) sb.push_back(next_tag + k);
        next_tag += FW;
        mc += FW;
      end
      step();
      checks++; if (int'(cnt0) !== mc) begin errs++; $display("FAIL fill_cnt c%0d got %0d want %0d", c, cnt0, mc); end
      checks++; if (sf0 !== (mc > DEP - FW)) begin errs++; $display("FAIL fill_sf c%0d got %b want %b", c, sf0, mc > DEP - FW); end
    end
    dready = 0; vec = '0; stall = 0;
    for (int c = 0; c < 8; c++) begin
      checks++; if (rdy0 !== (mc >= DW)) begin errs++; $display("FAIL drain_rdy c%0d got %b want %b", c, rdy0, mc >= DW); end
      for (int i = 0; i < DW; i++) begin
        checks++;
        if (tag0(i) !== sb[i]) begin errs++; $display("FAIL drain_lane%0d c%0d got %0d want %0d", i, c, tag0(i), sb[i]); end
      end
      step();
      repeat (DW) void'(sb.pop_front());
      mc -= DW;
      checks++; if (int'(cnt0) !== mc) begin errs++; $display("FAIL drain_cnt c%0d got %0d want %0d", c, cnt0, mc); end
      checks++; if (sf0 !== (mc > DEP - FW)) begin errs++; $display("FAIL drain_sf c%0d got %b want %b", c, sf0, mc > DEP - FW); end
    end
    stall = 1;
  endtask

  task automatic test_wrap();
    logic [FW-1:0] pats [5];
    int mc, av, ebc, pc;
    bit acc;
    pats[0] = 8'b0000_0111; pats[1] = 8'b1101_0110;
    pats[2] = 8'b0101_0101; pats[3] = 8'b1000_0001;
    pats[4] = 8'b0111_1110;
    mc = 0; stall = 0;
    for (int c = 0; c < 40; c++) begin
      av = (mc >= DW) ? DW : 0;
      checks++; if (rdy0 !== (av != 0)) begin errs++; $display("FAIL wrap_rdy c%0d got %b want %b", c, rdy0, av != 0); end
      checks++; if (int'(cnt0) !== mc) begin errs++; $display("FAIL wrap_cnt c%0d got %0d want %0d", c, cnt0, mc); end
      ebc = 0;
      for (int i = 0; i < av; i++) begin
        ebc += int'(isbr(sb[i]));
        checks++;
        if (tag0(i) !== sb[i]) begin errs++; $display("FAIL wrap_lane%0d c%0d got %0d want %0d", i, c, tag0(i), sb[i]); end
      end
      checks++; if (int'(bc0) !== ebc) begin errs++; $display("FAIL wrap_bc c%0d got %0d want %0d", c, bc0, ebc); end
      vec = pats[c % 5]; dready = 1;
      acc = (mc <= DEP - FW);
      pc = 0;
      for (int k = 0; k < FW; k++) begin
        if (vec[k] && acc) begin
          din[k*PW +: PW] = mkpkt(next_tag, isbr(next_tag));
          sb.push_back(next_tag);
          next_tag++;
          pc++;
        end else begin
          din[k*PW +: PW] = mkpkt(32'hFFFF, 1'b1);
        end
      end
      step();
      if (av != 0) begin
        repeat (DW) void'(sb.pop_front());
        mc -= DW;
      end
      if (acc) mc += pc;
    end
    dready = 0; vec = '0;
    for (int c = 0; c < 10; c++) begin
      if (mc >= DW) begin
        for (int i = 0; i < DW; i++) begin
          checks++;
          if (tag0(i) !== sb[i]) begin errs++; $display("FAIL wdrain_lane%0d got %0d want %0d", i, tag0(i), sb[i]); end
        end
        step();
        repeat (DW) void'(sb.pop_front());
        mc -= DW;
      end
    end
    checks++; if (int'(cnt0) !== mc) begin errs++; $display("FAIL wrap_end got %0d want %0d", cnt0, mc); end
    flush = 1;
    step();
    flush = 0; stall = 1;
    sb.delete();
  endtask

  task automatic test_flush();
    stall = 1; dready = 1; vec = 8'hFF;
    for (int k = 0; k < FW; k++) din[k*PW +: PW] = mkpkt(k, 1'b1);
    step();
    vec = 8'h0F;
    step();
    checks++; if (cnt0 !== 6'd12) begin errs++; $display("FAIL fl_pre got %0d want 12", cnt0); end
    flush = 1; vec = 8'hFF; stall = 0;
    step();
    flush = 0; dready = 0; vec = '0;
    checks++; if (cnt0 !== 6'd0) begin errs++; $display("FAIL fl_cnt got %0d want 0", cnt0); end
    checks++; if (dv0 !== 4'h0) begin errs++; $display("FAIL fl_dv got %h want 0", dv0); end
    checks++; if (rdy0 !== 1'b0) begin errs++; $display("FAIL fl_rdy got %b want 0", rdy0); end
    step();
    checks++; if (cnt0 !== 6'd0) begin errs++; $display("FAIL fl_hold got %0d want 0", cnt0); end
    stall = 1;
  endtask

  task automatic test_async_reset();
    stall = 1; dready = 1; vec = 8'hFF;
    repeat (4) step();
    checks++; if (cnt0 !== 6'd32) begin errs++; $display("FAIL ar_pre got %0d want 32", cnt0); end
    checks++; if (sf0 !== 1'b1) begin errs++; $display("FAIL ar_sf_pre got %b want 1", sf0); end
    #3;
    reset = 0; dready = 0; vec = '0;
    #1;
    checks++; if (cnt0 !== 6'd0) begin errs++; $display("FAIL ar_cnt got %0d want 0", cnt0); end
    checks++; if (sf0 !== 1'b0) begin errs++; $display("FAIL ar_sf got %b want 0", sf0); end
    checks++; if (rdy0 !== 1'b0) begin errs++; $display("FAIL ar_rdy got %b want 0", rdy0); end
    checks++; if (dv0 !== 4'h0) begin errs++; $display("FAIL ar_dv got %h want 0", dv0); end
    checks++; if (bc0 !== 3'd0) begin errs++; $display("FAIL ar_bc got %0d want 0", bc0); end
    checks++; if (cnt1 !== 6'd0) begin errs++; $display("FAIL ar_cnt1 got %0d want 0", cnt1); end
    #2 reset = 1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_write();
    test_sparse();
    test_partial();
    test_fill();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
